// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - issue/result bundle between the execute datapath and the multiply/divide unit
//
// Purpose: groups the operand issue, MTHI/MTLO write and HI/LO result signals of
// mult_div_unit so the datapath connects through a single port.
// Signals:
//   start, op, rs_data, rt_data : operation issue (op 00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   mthi, mtlo, wdata           : direct HI/LO writes
//   busy, done, div_by_zero     : status back to the control FSM
//   hi, lo                      : architectural HI/LO registers
// Modports: master = datapath/issuer, slave = mult_div_unit.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, mthi, mtlo, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, mthi, mtlo, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative multiply/divide unit owning the HI/LO registers
//
// Purpose: radix-2 shift-add multiplier and restoring divider, one bit per clock,
// fixed latency of WIDTH+1 edges from an accepted start to the done pulse.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : mult_div_unit_if slave (issue, MTHI/MTLO, busy/done/div_by_zero, hi/lo)
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  mult_div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [2*WIDTH-1:0] r_acc;      // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
  logic [WIDTH-1:0]   r_opnd;     // multiplicand / divisor magnitude
  logic [CW-1:0]      r_cnt;
  logic               r_neg_lo;   // negate product or quotient
  logic               r_neg_hi;   // negate remainder (dividend sign)
  logic               r_is_div;
  logic               r_dz;
  logic [WIDTH-1:0]   r_rs_raw;   // dividend as issued, returned in HI on divide-by-zero
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dz_out;

  logic               w_accept;
  logic               w_last;
  logic               w_rs_neg;
  logic               w_rt_neg;
  logic [WIDTH-1:0]   w_rs_mag;
  logic [WIDTH-1:0]   w_rt_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  // A start coinciding with the done pulse is refused so the issuer always sees
  // the completed result before the next operation begins.
  assign w_accept = (r_state == S_IDLE) && bus.start && !r_done;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  assign w_rs_neg = bus.op[0] & bus.rs_data[WIDTH-1];
  assign w_rt_neg = bus.op[0] & bus.rt_data[WIDTH-1];
  assign w_rs_mag = w_rs_neg ? -bus.rs_data : bus.rs_data;
  assign w_rt_mag = w_rt_neg ? -bus.rt_data : bus.rt_data;

  // Shift-add: add multiplicand into the upper half when the multiplier LSB is
  // set, then shift the whole accumulator (with carry) right by one.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring step: shift the next dividend bit into the remainder and keep the
  // subtraction only when it does not borrow.
  assign w_shift    = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_trial    = w_shift - {1'b0, r_opnd};
  assign w_div_next = w_trial[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                     : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod = r_neg_lo ? -r_acc : r_acc;

  always_comb begin
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_dz) begin
        w_fix_hi = r_rs_raw;
        w_fix_lo = '1;
      end else begin
        w_fix_hi = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        w_fix_lo = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = bus.op[1] ? S_DIV : S_MUL;
      S_MUL:   if (w_last) w_next = S_FIX;
      S_DIV:   if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc    <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
      r_rs_raw <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dz_out <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_dz_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc    <= {{WIDTH{1'b0}}, w_rs_mag};
            r_opnd   <= w_rt_mag;
            r_cnt    <= '0;
            r_neg_lo <= w_rs_neg ^ w_rt_neg;
            r_neg_hi <= w_rs_neg;
            r_is_div <= bus.op[1];
            r_dz     <= bus.op[1] && (bus.rt_data == '0);
            r_rs_raw <= bus.rs_data;
          end else if (!bus.start) begin
            if (bus.mthi) r_hi <= bus.wdata;
            if (bus.mtlo) r_lo <= bus.wdata;
          end
        end
        S_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + 1'b1;
        end
        S_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_hi     <= w_fix_hi;
          r_lo     <= w_fix_lo;
          r_done   <= 1'b1;
          r_dz_out <= r_dz;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dz_out;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;

endmodule
